// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, oversampled on en ticks, byte out with a done strobe.
// Optional even-parity bit and parity_err output: define UART_RX_PARITY_EN.
module uart_rx_8n1 #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             armed;
    logic [CNT_W-1:0] tick;
    logic [2:0]       bitn;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             par;
`endif

    // Two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // Frame state machine; strobes self-clear every clk, timing moves on en
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick      <= '0;
            bitn      <= '0;
            shift     <= '0;
            out       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (!armed) begin
                            if (s2) armed <= 1'b1;
                        end else if (!s2) begin
                            state <= START;
                            tick  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick == MID) begin
                            tick <= '0;
                            if (!s2) begin
                                state <= DATA;
                                bitn  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick <= tick + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (tick == LAST) begin
                            tick  <= '0;
                            shift <= {s2, shift[7:1]};
                            bitn  <= bitn + 3'd1;
                            if (bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick <= tick + CNT_W'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick == LAST) begin
                            tick  <= '0;
                            par   <= s2;
                            state <= STOP;
                        end else begin
                            tick <= tick + CNT_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (tick == LAST) begin
                            tick  <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (s2) begin
                                out  <= shift;
                                done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err <= ^{shift, par};
`endif
                            end else begin
                                frame_err <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end else begin
                            tick <= tick + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
